// File: rtl/exec_pkg.sv
// Shared definitions for the integer execution unit: widths, ALU opcodes,
// and the request/response payload shapes exchanged with RSV and ROB.
package exec_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned OP_W      = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [OP_W-1:0]      op;
        logic [XLEN-1:0]      a;
        logic [XLEN-1:0]      b;
    } exec_req_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      data;
        logic                 exc;
    } fill_rsp_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (op, a, b) -> (result, illegal).
module alu_core
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = exec_pkg::XLEN,
    parameter int unsigned OP_W = exec_pkg::OP_W
) (
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;
    logic           w_lt_s;
    logic           w_lt_u;

    assign w_shamt = i_b[SHW-1:0];
    assign w_lt_s  = $signed(i_a) < $signed(i_b);
    assign w_lt_u  = i_a < i_b;

    // Opcode decode; unknown opcodes yield zero and raise the illegal flag
    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
            ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_PASSB: o_result = i_b;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage integer execution unit: S1 operand latch, S2 result register
// feeding the ROB fill port, with full backpressure and synchronous flush.
module alu_exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned XLEN      = exec_pkg::XLEN,
    parameter int unsigned ROB_IDX_W = exec_pkg::ROB_IDX_W,
    parameter int unsigned OP_W      = exec_pkg::OP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [ROB_IDX_W-1:0] issue_rob_idx,
    input  logic [OP_W-1:0]      issue_op,
    input  logic [XLEN-1:0]      issue_src_a,
    input  logic [XLEN-1:0]      issue_src_b,
    input  logic [XLEN-1:0]      issue_imm,
    input  logic                 issue_use_imm,
    output logic                 fill_valid,
    input  logic                 fill_ready,
    output logic [ROB_IDX_W-1:0] fill_rob_idx,
    output logic [XLEN-1:0]      fill_data,
    output logic                 fill_exc,
    output logic [1:0]           busy_cnt
);

    logic                 r_s1_v;
    logic [ROB_IDX_W-1:0] r_s1_idx;
    logic [OP_W-1:0]      r_s1_op;
    logic [XLEN-1:0]      r_s1_a;
    logic [XLEN-1:0]      r_s1_b;

    logic                 r_s2_v;
    logic [ROB_IDX_W-1:0] r_s2_idx;
    logic [XLEN-1:0]      r_s2_data;
    logic                 r_s2_exc;

    logic                 w_s2_adv;
    logic                 w_accept;
    logic [XLEN-1:0]      w_alu_result;
    logic                 w_alu_illegal;

    // issue_ready depends only on state, flush and fill_ready, never on issue_valid
    assign w_s2_adv    = r_s1_v & (~r_s2_v | fill_ready);
    assign issue_ready = ~flush & (~r_s1_v | w_s2_adv);
    assign w_accept    = issue_valid & issue_ready;

    alu_core #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_alu_core (
        .i_op      (r_s1_op),
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .o_result  (w_alu_result),
        .o_illegal (w_alu_illegal)
    );

    // S1: latch operands on accept, empty when moved on without a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_idx <= '0;
            r_s1_op  <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
        end else if (flush) begin
            r_s1_v <= 1'b0;
        end else if (w_accept) begin
            r_s1_v   <= 1'b1;
            r_s1_idx <= issue_rob_idx;
            r_s1_op  <= issue_op;
            r_s1_a   <= issue_src_a;
            r_s1_b   <= issue_use_imm ? issue_imm : issue_src_b;
        end else if (w_s2_adv) begin
            r_s1_v <= 1'b0;
        end
    end

    // S2: register the ALU result on advance, empty once the ROB takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v    <= 1'b0;
            r_s2_idx  <= '0;
            r_s2_data <= '0;
            r_s2_exc  <= 1'b0;
        end else if (flush) begin
            r_s2_v <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v    <= 1'b1;
            r_s2_idx  <= r_s1_idx;
            r_s2_data <= w_alu_result;
            r_s2_exc  <= w_alu_illegal;
        end else if (fill_ready) begin
            r_s2_v <= 1'b0;
        end
    end

    assign fill_valid   = r_s2_v;
    assign fill_rob_idx = r_s2_idx;
    assign fill_data    = r_s2_data;
    assign fill_exc     = r_s2_exc;
    assign busy_cnt     = {1'b0, r_s1_v} + {1'b0, r_s2_v};

endmodule
